// File: rtl/q_engs_disp.sv
// Round-robin command dispatcher and response collector for an array of ENGINES_N engines.
// Optional Q_ENGS_DISP_STATS_EN adds saturating dispatch/stall counters (stat_disp_cnt, stat_stall_cnt).
module q_engs_disp #(
  parameter int ENGINES_N = 4,
  parameter int CMD_W     = 32,
  parameter int RSP_W     = 32,
  localparam int IDX_W    = $clog2(ENGINES_N)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_vld,
  output logic                         cmd_rdy,
  input  logic [CMD_W-1:0]             cmd_data,
  input  logic [ENGINES_N-1:0]         eng_en,
  output logic [ENGINES_N-1:0]         eng_req_vld,
  output logic [CMD_W-1:0]             eng_req_data,
  input  logic [ENGINES_N-1:0]         eng_rsp_vld,
  input  logic [ENGINES_N*RSP_W-1:0]   eng_rsp_data,
  output logic [ENGINES_N-1:0]         eng_rsp_rdy,
  output logic                         rsp_vld,
  input  logic                         rsp_rdy,
  output logic [RSP_W-1:0]             rsp_data,
  output logic [IDX_W-1:0]             rsp_eng,
  output logic                         idle,
  output logic                         err
`ifdef Q_ENGS_DISP_STATS_EN
  ,
  output logic [31:0]                  stat_disp_cnt,
  output logic [31:0]                  stat_stall_cnt
`endif
);

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit of vec, scanning upward from ptr with wrap at ENGINES_N.
  function automatic pick_t rr_pick(input logic [ENGINES_N-1:0] vec, input logic [IDX_W-1:0] ptr);
    pick_t            p;
    logic [IDX_W-1:0] j;
    logic             hit;
    p.found = 1'b0;
    p.idx   = '0;
    for (int k = 0; k < ENGINES_N; k++) begin
      j       = IDX_W'((int'(ptr) + k) % ENGINES_N);
      hit     = vec[j] & ~p.found;
      p.idx   = hit ? j : p.idx;
      p.found = p.found | vec[j];
    end
    return p;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return IDX_W'((int'(i) + 1) % ENGINES_N);
  endfunction

  function automatic logic [ENGINES_N-1:0] onehot(input logic [IDX_W-1:0] i);
    return {{(ENGINES_N-1){1'b0}}, 1'b1} << i;
  endfunction

  logic [ENGINES_N-1:0] busy_r;
  logic [ENGINES_N-1:0] eng_req_vld_r;
  logic [ENGINES_N-1:0] ack_q_r;
  logic [IDX_W-1:0]     disp_ptr_r;
  logic [IDX_W-1:0]     rsp_ptr_r;
  logic [IDX_W-1:0]     rsp_eng_r;
  logic [CMD_W-1:0]     eng_req_data_r;
  logic [RSP_W-1:0]     rsp_data_r;
  logic                 rsp_vld_r;
  logic                 err_r;

  logic [ENGINES_N-1:0] elig_s;
  logic [ENGINES_N-1:0] cand_s;
  logic [ENGINES_N-1:0] ack_s;
  logic [ENGINES_N-1:0] busy_nxt_s;
  logic [ENGINES_N-1:0] spur_s;
  logic [RSP_W-1:0]     rsp_slice_s;
  pick_t                disp_pick_s;
  pick_t                rsp_pick_s;
  logic                 cmd_rdy_s;
  logic                 disp_fire_s;
  logic                 out_free_s;
  logic                 rsp_fire_s;

  // Dispatch/collection selection, busy next-state and protocol-error detection.
  always_comb begin
    elig_s      = eng_en & ~busy_r;
    cmd_rdy_s   = |elig_s;
    disp_pick_s = rr_pick(elig_s, disp_ptr_r);
    disp_fire_s = cmd_vld & cmd_rdy_s;
    out_free_s  = ~rsp_vld_r | rsp_rdy;
    // The engine acked last cycle may still show valid; never pick it twice.
    cand_s      = eng_rsp_vld & busy_r & ~ack_q_r;
    rsp_pick_s  = rr_pick(cand_s, rsp_ptr_r);
    rsp_fire_s  = out_free_s & rsp_pick_s.found & ~rst;
    ack_s       = rsp_fire_s ? onehot(rsp_pick_s.idx) : {ENGINES_N{1'b0}};
    busy_nxt_s  = (busy_r | (disp_fire_s ? onehot(disp_pick_s.idx) : {ENGINES_N{1'b0}})) & ~ack_s;
    spur_s      = eng_rsp_vld & ((~busy_r & ~ack_q_r) | eng_req_vld_r);
    rsp_slice_s = eng_rsp_data[rsp_pick_s.idx * RSP_W +: RSP_W];
  end

  // Engine state, dispatch strobe, output register and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r         <= '0;
      eng_req_vld_r  <= '0;
      ack_q_r        <= '0;
      disp_ptr_r     <= '0;
      rsp_ptr_r      <= '0;
      rsp_eng_r      <= '0;
      eng_req_data_r <= '0;
      rsp_data_r     <= '0;
      rsp_vld_r      <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      busy_r        <= busy_nxt_s;
      eng_req_vld_r <= disp_fire_s ? onehot(disp_pick_s.idx) : {ENGINES_N{1'b0}};
      ack_q_r       <= ack_s;
      err_r         <= err_r | (|spur_s);
      if (disp_fire_s) begin
        eng_req_data_r <= cmd_data;
        disp_ptr_r     <= next_idx(disp_pick_s.idx);
      end
      if (rsp_fire_s) begin
        rsp_vld_r  <= 1'b1;
        rsp_data_r <= rsp_slice_s;
        rsp_eng_r  <= rsp_pick_s.idx;
        rsp_ptr_r  <= next_idx(rsp_pick_s.idx);
      end else if (out_free_s) begin
        rsp_vld_r  <= 1'b0;
      end
    end
  end

  assign cmd_rdy      = cmd_rdy_s;
  assign eng_req_vld  = eng_req_vld_r;
  assign eng_req_data = eng_req_data_r;
  assign eng_rsp_rdy  = ack_s;
  assign rsp_vld      = rsp_vld_r;
  assign rsp_data     = rsp_data_r;
  assign rsp_eng      = rsp_eng_r;
  assign idle         = ~(|busy_r) & ~rsp_vld_r;
  assign err          = err_r;

`ifdef Q_ENGS_DISP_STATS_EN
  logic [31:0] disp_cnt_r;
  logic [31:0] stall_cnt_r;

  // Saturating counters of accepted commands and stalled command cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_cnt_r  <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (disp_fire_s && (disp_cnt_r != 32'hFFFF_FFFF)) begin
        disp_cnt_r <= disp_cnt_r + 32'd1;
      end
      if (cmd_vld && !cmd_rdy_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
    end
  end

  assign stat_disp_cnt  = disp_cnt_r;
  assign stat_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_q_engs_disp.sv
// Directed and randomized bench for q_engs_disp (N=4) against a cycle-level reference model.
module tb_q_engs_disp;
  localparam int N  = 4;
  localparam int CW = 32;
  localparam int RW = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, cmd_vld, cmd_rdy, rsp_vld, rsp_rdy, idle, err;
  logic [CW-1:0]   cmd_data, eng_req_data;
  logic [N-1:0]    eng_en, eng_req_vld, eng_rsp_vld, eng_rsp_rdy;
  logic [N*RW-1:0] eng_rsp_data;
  logic [RW-1:0]   rsp_data;
  logic [IW-1:0]   rsp_eng;
`ifdef Q_ENGS_DISP_STATS_EN
  logic [31:0]     stat_disp_cnt, stat_stall_cnt;
`endif

  q_engs_disp #(.ENGINES_N(N), .CMD_W(CW), .RSP_W(RW)) dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_data(cmd_data),
    .eng_en(eng_en), .eng_req_vld(eng_req_vld), .eng_req_data(eng_req_data),
    .eng_rsp_vld(eng_rsp_vld), .eng_rsp_data(eng_rsp_data), .eng_rsp_rdy(eng_rsp_rdy),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_eng(rsp_eng),
    .idle(idle), .err(err)
`ifdef Q_ENGS_DISP_STATS_EN
    , .stat_disp_cnt(stat_disp_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  // Engine models: respond some cycles after their strobe, drop valid after the ack.
  logic [N-1:0]  e_rsp;
  logic [N-1:0]  spur;
  logic [RW-1:0] e_data [N];
  int            e_cnt  [N];
  bit            auto_eng;
  int            fix_delay;

  for (genvar g = 0; g < N; g++) begin : g_eng
    assign eng_rsp_vld[g]             = e_rsp[g] | spur[g];
    assign eng_rsp_data[g*RW +: RW]   = e_data[g];
  end

  // Reference model state (engine-level view).
  bit            m_busy [N];
  int            m_dptr, m_rptr, m_req, m_ack_prev, m_rsp_eng;
  logic [CW-1:0] m_req_data;
  logic [RW-1:0] m_rsp_data;
  bit            m_rsp_vld, m_err;
  longint        m_disp_cnt, m_stall_cnt;
  int            x_sel, x_pick;
  bit            x_rdy, x_free, x_spur;
  logic [RW-1:0] x_pick_data;
  logic [N-1:0]  ack_seen, strobe_seen;
  int            strobe_log[$];
  int            accepted;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
    m_dptr = 0; m_rptr = 0; m_req = -1; m_ack_prev = -1; m_rsp_eng = 0;
    m_req_data = '0; m_rsp_data = '0; m_rsp_vld = 1'b0; m_err = 1'b0;
    m_disp_cnt = 0; m_stall_cnt = 0;
  endtask

  task automatic model_comb();
    int idx;
    x_rdy = 1'b0;
    for (int i = 0; i < N; i++) if (eng_en[i] && !m_busy[i]) x_rdy = 1'b1;
    x_sel = -1;
    if (cmd_vld && x_rdy)
      for (int k = 0; k < N; k++) begin
        idx = (m_dptr + k) % N;
        if (x_sel < 0 && eng_en[idx] && !m_busy[idx]) x_sel = idx;
      end
    x_free = !m_rsp_vld || rsp_rdy;
    x_pick = -1;
    if (x_free && !rst)
      for (int k = 0; k < N; k++) begin
        idx = (m_rptr + k) % N;
        if (x_pick < 0 && eng_rsp_vld[idx] && m_busy[idx] && idx != m_ack_prev) x_pick = idx;
      end
    x_pick_data = (x_pick >= 0) ? e_data[x_pick] : '0;
    x_spur = 1'b0;
    for (int i = 0; i < N; i++)
      if (eng_rsp_vld[i] && ((!m_busy[i] && i != m_ack_prev) || i == m_req)) x_spur = 1'b1;
  endtask

  task automatic check_outputs();
    bit any_busy;
    any_busy = 1'b0;
    for (int i = 0; i < N; i++) any_busy |= m_busy[i];
    chk("cmd_rdy", 64'(cmd_rdy), 64'(x_rdy));
    chk("eng_rsp_rdy", 64'(eng_rsp_rdy), (x_pick < 0) ? 64'd0 : 64'(1 << x_pick));
    chk("eng_req_vld", 64'(eng_req_vld), (m_req < 0) ? 64'd0 : 64'(1 << m_req));
    if (m_req >= 0) chk("eng_req_data", 64'(eng_req_data), 64'(m_req_data));
    chk("rsp_vld", 64'(rsp_vld), 64'(m_rsp_vld));
    if (m_rsp_vld) begin
      chk("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
      chk("rsp_eng", 64'(rsp_eng), 64'(m_rsp_eng));
    end
    chk("idle", 64'(idle), 64'(!any_busy && !m_rsp_vld));
    chk("err", 64'(err), 64'(m_err));
`ifdef Q_ENGS_DISP_STATS_EN
    chk("stat_disp", 64'(stat_disp_cnt), 64'(m_disp_cnt));
    chk("stat_stall", 64'(stat_stall_cnt), 64'(m_stall_cnt));
`endif
  endtask

  task automatic model_advance();
    if (rst) begin
      model_reset();
    end else begin
      if (cmd_vld && !x_rdy) m_stall_cnt++;
      if (x_sel >= 0) begin
        m_busy[x_sel] = 1'b1; m_dptr = (x_sel + 1) % N; m_req = x_sel;
        m_req_data = cmd_data; accepted++; m_disp_cnt++;
      end else m_req = -1;
      if (x_pick >= 0) begin
        m_busy[x_pick] = 1'b0; m_rsp_vld = 1'b1; m_rsp_data = x_pick_data;
        m_rsp_eng = x_pick; m_rptr = (x_pick + 1) % N; m_ack_prev = x_pick;
      end else begin
        m_ack_prev = -1;
        if (x_free) m_rsp_vld = 1'b0;
      end
      if (x_spur) m_err = 1'b1;
    end
  endtask

  task automatic engines_advance();
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        e_rsp[i] = 1'b0; e_cnt[i] = -1;
      end else begin
        if (ack_seen[i]) e_rsp[i] = 1'b0;
        if (strobe_seen[i]) e_cnt[i] = !auto_eng ? -1 : (fix_delay >= 0 ? fix_delay : int'($urandom_range(3)));
        else if (e_cnt[i] > 0) e_cnt[i]--;
        else if (e_cnt[i] == 0) begin e_rsp[i] = 1'b1; e_data[i] = $urandom; e_cnt[i] = -1; end
      end
    end
  endtask

  // One clock: check at negedge, advance model and engines just after posedge.
  task automatic tick();
    @(negedge clk);
    model_comb();
    check_outputs();
    ack_seen = eng_rsp_rdy;
    strobe_seen = eng_req_vld;
    for (int i = 0; i < N; i++) if (eng_req_vld[i]) strobe_log.push_back(i);
    @(posedge clk);
    #1;
    model_advance();
    engines_advance();
  endtask

  task automatic reset_tick();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin
    int exp_order[3];
    rst = 1'b1; cmd_vld = 1'b0; cmd_data = '0; eng_en = '0; rsp_rdy = 1'b1; spur = '0;
    e_rsp = '0; auto_eng = 1'b0; fix_delay = -1; accepted = 0;
    for (int i = 0; i < N; i++) begin e_data[i] = '0; e_cnt[i] = -1; end
    @(posedge clk); #1;
    model_reset(); rst = 1'b0;
    chk("rst_req_vld", 64'(eng_req_vld), 64'd0);
    chk("rst_req_data", 64'(eng_req_data), 64'd0);
    chk("rst_rsp_rdy", 64'(eng_rsp_rdy), 64'd0);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_eng", 64'(rsp_eng), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_cmd_rdy", 64'(cmd_rdy), 64'd0);

    // Round-robin dispatch over all four engines.
    eng_en = 4'hF; cmd_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_data = 32'h10 + 32'(i);
      tick();
      chk("rr_strobe", 64'(eng_req_vld), 64'(1 << i));
      chk("rr_data", 64'(eng_req_data), 64'(32'h10 + 32'(i)));
    end
    cmd_vld = 1'b0; #1;
    chk("rr_full_rdy", 64'(cmd_rdy), 64'd0);
    tick();
    reset_tick();

    // Enable mask 1010 with engines completing two cycles after their strobe.
    eng_en = 4'b1010; auto_eng = 1'b1; fix_delay = 0; rsp_rdy = 1'b1;
    strobe_log.delete(); accepted = 0; cmd_vld = 1'b1;
    for (int c = 0; c < 40 && (accepted < 3 || strobe_log.size() < 3); c++) begin
      cmd_data = $urandom;
      tick();
      if (accepted >= 3) cmd_vld = 1'b0;
    end
    cmd_vld = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    exp_order[0] = 1; exp_order[1] = 3; exp_order[2] = 1;
    chk("mask_count", 64'(strobe_log.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk("mask_order", (i < strobe_log.size()) ? 64'(strobe_log[i]) : 64'hDEAD, 64'(exp_order[i]));
    chk("mask_idle", 64'(idle), 64'd1);
    auto_eng = 1'b0; fix_delay = -1;
    reset_tick();

    // All four engines respond together: collected 0,1,2,3.
    eng_en = 4'hF; cmd_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin cmd_data = $urandom; tick(); end
    cmd_vld = 1'b0; tick();
    for (int i = 0; i < N; i++) begin e_rsp[i] = 1'b1; e_data[i] = 32'hA0 + 32'(i); end
    rsp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arb_vld", 64'(rsp_vld), 64'd1);
      chk("arb_eng", 64'(rsp_eng), 64'(i));
      chk("arb_data", 64'(rsp_data), 64'(32'hA0 + 32'(i)));
    end
    tick();
    chk("arb_idle", 64'(idle), 64'd1);
    chk("arb_drain", 64'(rsp_vld), 64'd0);
    reset_tick();

    // Output backpressure holds engine 2's response; engine 1 waits for the handshake.
    eng_en = 4'hF; cmd_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin cmd_data = $urandom; tick(); end
    cmd_vld = 1'b0; tick();
    rsp_rdy = 1'b0; e_rsp[2] = 1'b1; e_data[2] = 32'h55;
    tick();
    e_rsp[1] = 1'b1; e_data[1] = 32'h66;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_vld", 64'(rsp_vld), 64'd1);
      chk("bp_data", 64'(rsp_data), 64'h55);
      chk("bp_eng", 64'(rsp_eng), 64'd2);
      chk("bp_noack", 64'(eng_rsp_rdy), 64'd0);
      tick();
    end
    rsp_rdy = 1'b1; #1;
    chk("bp_ack1", 64'(eng_rsp_rdy), 64'b0010);
    tick();
    chk("bp_next_eng", 64'(rsp_eng), 64'd1);
    chk("bp_next_data", 64'(rsp_data), 64'h66);
    tick(); tick();
    reset_tick();

    // Spurious response from idle engine 3.
    spur = 4'b1000;
    tick();
    chk("spur_err", 64'(err), 64'd1);
    chk("spur_fwd", 64'(rsp_vld), 64'd0);
    spur = 4'b0000;
    tick();
    chk("spur_sticky", 64'(err), 64'd1);
    chk("spur_nofwd", 64'(rsp_vld), 64'd0);

    // Reset while engines are busy and a response is held.
    eng_en = 4'hF; cmd_vld = 1'b1;
    for (int i = 0; i < 2; i++) begin cmd_data = $urandom; tick(); end
    cmd_vld = 1'b0; tick();
    rsp_rdy = 1'b0; e_rsp[0] = 1'b1; e_data[0] = 32'h77;
    tick();
    reset_tick(); #1;
    chk("mrst_err", 64'(err), 64'd0);
    chk("mrst_idle", 64'(idle), 64'd1);
    chk("mrst_ack", 64'(eng_rsp_rdy), 64'd0);
    chk("mrst_vld", 64'(rsp_vld), 64'd0);
    rsp_rdy = 1'b1;
    tick();

`ifdef Q_ENGS_DISP_STATS_EN
    // Six commands against two enabled, silent engines.
    reset_tick();
    eng_en = 4'b0011; cmd_vld = 1'b1;
    for (int i = 0; i < 6; i++) begin cmd_data = $urandom; tick(); end
    cmd_vld = 1'b0;
    chk("stat_disp_cnt", 64'(stat_disp_cnt), 64'd2);
    chk("stat_stall_cnt", 64'(stat_stall_cnt), 64'd4);
    tick();
`endif

    // Randomized traffic with well-behaved engines.
    reset_tick();
    auto_eng = 1'b1; fix_delay = -1;
    for (int c = 0; c < 800; c++) begin
      if (c % 25 == 0) eng_en = 4'($urandom_range(15));
      cmd_vld  = 1'($urandom_range(1));
      cmd_data = $urandom;
      rsp_rdy  = ($urandom_range(3) != 0);
      tick();
    end
    cmd_vld = 1'b0; rsp_rdy = 1'b1;
    for (int c = 0; c < 30; c++) tick();
    chk("rand_idle", 64'(idle), 64'd1);
    chk("rand_err", 64'(err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
